layer_output_serializer: RTL and testbench

Collects the parallel outputs of one layer's neuron array and replays them as a single serial stream into the next layer's neurons (their `myInput`/`myInputValid` port pair). All neurons of a layer share one input stream, so their `outvalid` strobes are coincident. This block captures the whole output vector on that strobe and emits one element per cycle, neuron 0 first. It sits between layer N's neurons and layer N+1's neurons.

---
 rtl/layer_output_serializer.sv | 136 +++++++++++++
 tb/tb_layer_output_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_output_serializer.sv
// Captures one layer's parallel neuron outputs and replays them serially.
// Define LAYER_ARGMAX_EN to track the signed argmax of each emitted vector.
module layer_output_serializer #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16,
  parameter int cntWidth  = $clog2(numNeuron)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron-1:0]           xValid,
  input  logic [numNeuron*dataWidth-1:0] xIn,
  output logic [dataWidth-1:0]           dataOut,
  output logic                           dataValid,
  output logic                           busy,
  output logic                           overrun,
  output logic [cntWidth-1:0]            maxIdx,
  output logic                           maxValid
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [cntWidth-1:0] LAST = cntWidth'(numNeuron - 1);

  state_t               state_q, state_d;
  logic [dataWidth-1:0] buf_q [numNeuron];
  logic [dataWidth-1:0] buf_d [numNeuron];
  logic [cntWidth-1:0]  cnt_q, cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 cap;
  logic                 last;
  logic                 unused_xvalid;

  // Only neuron 0's strobe matters; all strobes in a layer coincide.
  assign unused_xvalid = ^xValid[numNeuron-1:1];

  assign busy      = (state_q == SHIFT);
  assign dataValid = busy;
  assign dataOut   = busy ? buf_q[cnt_q] : '0;
  assign overrun   = overrun_q;
  assign last      = busy && (cnt_q == LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    overrun_d = overrun_q;
    cap       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xValid[0]) cap = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (xValid[0]) cap = 1'b1;
          else state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (xValid[0]) overrun_d = 1'b1;
        end
      end
    endcase
    if (cap) begin
      for (int k = 0; k < numNeuron; k++)
        buf_d[k] = xIn[k*dataWidth +: dataWidth];
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < numNeuron; k++)
        buf_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      buf_q     <= buf_d;
    end
  end

`ifdef LAYER_ARGMAX_EN
  logic signed [dataWidth-1:0] cur;
  logic signed [dataWidth-1:0] max_q, max_d;
  logic [cntWidth-1:0]         idx_q, idx_d;
  logic [cntWidth-1:0]         max_idx_q, max_idx_d;
  logic                        max_valid_q, max_valid_d;
  logic                        take;
  logic [cntWidth-1:0]         new_idx;

  assign cur = dataOut;

  // Strict compare so a tie keeps the lower index; beat 0 seeds the max.
  always_comb begin
    max_d       = max_q;
    idx_d       = idx_q;
    max_idx_d   = max_idx_q;
    max_valid_d = 1'b0;
    take        = busy && ((cnt_q == '0) || (cur > max_q));
    new_idx     = take ? cnt_q : idx_q;
    if (take) begin
      max_d = cur;
      idx_d = cnt_q;
    end
    if (last) begin
      max_idx_d   = new_idx;
      max_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q       <= '0;
      idx_q       <= '0;
      max_idx_q   <= '0;
      max_valid_q <= 1'b0;
    end else begin
      max_q       <= max_d;
      idx_q       <= idx_d;
      max_idx_q   <= max_idx_d;
      max_valid_q <= max_valid_d;
    end
  end

  assign maxIdx   = max_idx_q;
  assign maxValid = max_valid_q;
`else
  assign maxIdx   = '0;
  assign maxValid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer with 4 neurons of 16 bits.
// Argmax checks run when LAYER_ARGMAX_EN is defined.
module tb_layer_output_serializer;

  localparam int NN = 4;
  localparam int DW = 16;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NN-1:0]    xValid = '0;
  logic [NN*DW-1:0] xIn = '0;
  logic [DW-1:0]    dataOut;
  logic             dataValid;
  logic             busy;
  logic             overrun;
  logic [CW-1:0]    maxIdx;
  logic             maxValid;

  int errs = 0;
  int checks = 0;

  localparam logic [63:0] VA = 64'h0004_0003_0002_0001;
  localparam logic [63:0] VB = 64'h0013_0012_0011_0010;
  localparam logic [63:0] VM = 64'h8000_0005_0005_FFFF;

  always #5 clk = ~clk;

  layer_output_serializer #(
    .numNeuron(NN),
    .dataWidth(DW),
    .cntWidth (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .xValid   (xValid),
    .xIn      (xIn),
    .dataOut  (dataOut),
    .dataValid(dataValid),
    .busy     (busy),
    .overrun  (overrun),
    .maxIdx   (maxIdx),
    .maxValid (maxValid)
  );

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; xValid = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic send(input logic [63:0] v);
    @(posedge clk); #1 xIn = v; xValid = 4'b0001;
    @(posedge clk); #1 xValid = '0;
  endtask

  task automatic chk_beat(input string nm, input logic [DW-1:0] exp);
    checks++;
    if (dataOut !== exp || dataValid !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL %s: dataOut=%h dv=%b busy=%b, need %h 1 1",
               nm, dataOut, dataValid, busy, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    checks++;
    if (dataOut !== '0 || dataValid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s: dataOut=%h dv=%b busy=%b, need 0 0 0",
               nm, dataOut, dataValid, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({dataOut, dataValid, busy, overrun, maxIdx, maxValid} !== '0) begin
        errs++;
        $display("FAIL reset_idle[%0d]: d=%h dv=%b b=%b ov=%b mi=%0d mv=%b, need 0",
                 i, dataOut, dataValid, busy, overrun, maxIdx, maxValid);
      end
    end
  endtask

  task automatic test_ignore_high_bits();
    @(posedge clk); #1 xIn = VA; xValid = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("ignore_high");
    end
    @(posedge clk); #1 xValid = '0;
  endtask

  task automatic test_single();
    logic [DW-1:0] e [4] = '{16'h1, 16'h2, 16'h3, 16'h4};
    send(VA);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_beat($sformatf("single_beat%0d", k), e[k]);
    end
    @(negedge clk);
    chk_idle("single_end");
    checks++;
    if (overrun !== 1'b0) begin
      errs++;
      $display("FAIL single_overrun: got %b need 0", overrun);
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] e [4] = '{16'h1, 16'h2, 16'h3, 16'h4};
    send(VA);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin xIn = VB; xValid = 4'b0001; end
      @(negedge clk);
      chk_beat($sformatf("ovr_beat%0d", k), e[k]);
      @(posedge clk); #1 xValid = '0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("ovr_no_second");
      checks++;
      if (overrun !== 1'b1) begin
        errs++;
        $display("FAIL ovr_sticky: got %b need 1", overrun);
      end
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errs++;
      $display("FAIL ovr_clear: got %b need 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e [8] = '{16'h1, 16'h2, 16'h3, 16'h4,
                             16'h10, 16'h11, 16'h12, 16'h13};
    send(VA);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin xIn = VB; xValid = 4'b0001; end
      @(negedge clk);
      chk_beat($sformatf("b2b_beat%0d", k), e[k]);
`ifdef LAYER_ARGMAX_EN
      if (k == 4) begin
        checks++;
        if (maxValid !== 1'b1 || maxIdx !== 2'd3) begin
          errs++;
          $display("FAIL b2b_argmax: mv=%b mi=%0d need 1 3", maxValid, maxIdx);
        end
      end
`endif
      @(posedge clk); #1 xValid = '0;
    end
    @(negedge clk);
    chk_idle("b2b_end");
    checks++;
    if (overrun !== 1'b0) begin
      errs++;
      $display("FAIL b2b_overrun: got %b need 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e [4] = '{16'h10, 16'h11, 16'h12, 16'h13};
    send(VA);
    @(negedge clk); chk_beat("rmid_beat0", 16'h1);
    @(posedge clk); #1;
    @(negedge clk); chk_beat("rmid_beat1", 16'h2);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk_beat("rmid_beat2", 16'h3);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk_idle("rmid_after");
    @(negedge clk); chk_idle("rmid_stay");
    send(VB);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_beat($sformatf("rmid_replay%0d", k), e[k]);
    end
    @(negedge clk);
    chk_idle("rmid_end");
  endtask

  task automatic test_argmax();
    do_reset();
    send(VM);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (maxValid !== 1'b0) begin
        errs++;
        $display("FAIL argmax_early%0d: mv=%b need 0", k, maxValid);
      end
    end
    @(negedge clk);
    checks++;
`ifdef LAYER_ARGMAX_EN
    if (maxValid !== 1'b1 || maxIdx !== 2'd1) begin
      errs++;
      $display("FAIL argmax_result: mv=%b mi=%0d need 1 1", maxValid, maxIdx);
    end
    @(negedge clk);
    checks++;
    if (maxValid !== 1'b0 || maxIdx !== 2'd1) begin
      errs++;
      $display("FAIL argmax_hold: mv=%b mi=%0d need 0 1", maxValid, maxIdx);
    end
`else
    if (maxValid !== 1'b0 || maxIdx !== 2'd0) begin
      errs++;
      $display("FAIL argmax_tieoff: mv=%b mi=%0d need 0 0", maxValid, maxIdx);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ignore_high_bits();
    test_single();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_argmax();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
